adder_share_sched: RTL and testbench
====================================

# adder_share_sched

Round-robin scheduler that shares one 4-bit ripple-carry adder slice between two requesters and sequences it nibble-serially to add WIDTH-bit operands. It sits between two client blocks and the adder datapath. It accepts one operation at a time over valid/ready, runs WIDTH/4 adder passes with a registered inter-nibble carry, and returns sum, carry-out and requester id over a valid/ready response port.

## Interface
- WIDTH, 16: operand width; multiple of 4, ≥ 4. NIB = WIDTH/4.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  id of the requester served.
- rsp_sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- rsp_cout  out  1  carry out of bit WIDTH-1.
- busy  out  1  high in RUN or DONE.

## Operation
- The FSM has three states.
  - IDLE: arbitration is active.
  - RUN: nibble counter k runs from 0 to NIB-1.
  - DONE: rsp_valid is high.
- Arbitration is done in IDLE only.
  - grant = the requester whose valid is high. If both are valid, grant = prio.
  - reqX_ready = (state==IDLE) && reqX_valid && grant==X. This is combinational; at most one ready is high.
  - A requester holds valid and its data stable until it sees ready.
- Accept (valid & ready):
  - Latch a, b and id.
  - carry register ← cin.
  - k ← 0.
  - Sum register ← 0.
  - Go to RUN.
- RUN, each cycle:
  - The adder computes a[4k+3:4k] + b[4k+3:4k] + carry.
  - Sum register nibble k ← S.
  - carry ← C4.
  - If k==NIB-1, go to DONE. Otherwise k ← k+1.
- DONE:
  - rsp_sum = sum register, rsp_cout = carry, rsp_id = latched id.
  - All three are stable while rsp_valid is high.
  - On rsp_ready: go to IDLE and set prio ← ~rsp_id.
  - No new request is accepted while in DONE.
- Width rules:
  - There is no saturation; overflow shows only in rsp_cout.
  - Carry propagates across nibbles only through the carry register.
- Reset values:
  - state IDLE, prio 0, k 0, carry 0.
  - rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, busy 0.
  - req0_ready and req1_ready are 0 in the reset cycle; they are gated off by rst.
- Reset mid-operation (RUN or DONE): the operation is discarded, no response is emitted, and prio returns to 0.

## Timing
- Accept edge = E0. RUN occupies edges E1..E_NIB. rsp_valid is high from E_NIB onward, i.e. NIB cycles after the accept edge (4 for WIDTH=16).
- A response handshake at edge Er returns the FSM to IDLE. The earliest next accept is Er+1.
- Back-to-back throughput is one operation per NIB+2 cycles when rsp_ready is held high.
- rsp_ready low stalls the block in DONE indefinitely. The outputs hold and both readies stay 0.
- Simultaneous valids in IDLE: grant = prio. The loser keeps valid asserted and is granted next if it is still valid.
- A valid rising while the block is busy is not acknowledged until IDLE.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the localparam NIB = WIDTH/4;
  - the counter width $clog2(NIB), minimum 1.
- One sub-module: a single instance of the existing ripple_carry_4_bit_adder.
  - Its inputs are the selected nibble of a and b plus the carry register.
  - Its outputs S and C4 feed the sum and carry registers.
  - No other adder logic is allowed.
- Arbitration, the counter and nibble muxing are inline in the block.

## Test plan
1. req0 only, a=0x1234, b=0x0FCD, cin=0 → rsp_sum=0x2201, rsp_cout=0, rsp_id=0. rsp_valid rises 4 cycles after accept; busy is high throughout.
2. req1 only, a=0xFFFF, b=0x0000, cin=1 → rsp_sum=0x0000, rsp_cout=1, rsp_id=1. This proves carry ripples through all four nibbles.
3. Both valid continuously from reset, rsp_ready=1 → rsp_id sequence 0,1,0,1. Each req_ready pulses exactly once per operation, 6 cycles apart.
4. rsp_ready held low for 5 cycles in DONE → rsp_valid, rsp_sum and rsp_cout stay stable; req0_ready and req1_ready stay 0. After rsp_ready=1, the next accept occurs on the following edge.
5. rst asserted during RUN at k=2 → no rsp_valid. The next operation (req1 and req0 both valid) is granted to req0 with the correct result, e.g. 0x8000+0x8000+0 → sum 0x0000, cout 1.
6. a=0xFFFF, b=0xFFFF, cin=1 → rsp_sum=0xFFFF, rsp_cout=1. Then a=0x000F, b=0x0001, cin=0 → rsp_sum=0x0010, rsp_cout=0, with no stale carry from the prior operation.

Source files
------------

// File: rtl/adder_share_sched_pkg.sv
// rtl/adder_share_sched_pkg.sv - shared types and sizing helpers for the nibble-serial adder scheduler
package adder_share_sched_pkg;

  // Three-state operation sequencer: arbitrate, run nibble passes, hold result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NIB   = DEF_WIDTH / 4;
  localparam int DEF_CNT_W = (DEF_NIB > 1) ? $clog2(DEF_NIB) : 1;

  // Number of 4-bit adder passes needed for an operand of width w
  function automatic int nib_count(input int w);
    return w / 4;
  endfunction

  // Nibble counter width; never below one bit so a single-pass build still has a counter
  function automatic int cnt_width(input int w);
    return ((w / 4) > 1) ? $clog2(w / 4) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_4_bit_adder.sv
// rtl/ripple_carry_4_bit_adder.sv - 4-bit ripple-carry adder slice shared by both requesters
module ripple_carry_4_bit_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c0_i,
  output logic [3:0] s_o,
  output logic       c4_o
);

  logic carry;

  // Bitwise full-adder chain, carry rippling from bit 0 to bit 3
  always_comb begin
    carry = c0_i;
    s_o   = '0;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c4_o = carry;
  end

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin sharing of one 4-bit adder slice, sequenced nibble-serially
module adder_share_sched
  import adder_share_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             busy
);

  localparam int NIB = nib_count(WIDTH);
  localparam int CW  = cnt_width(WIDTH);
  localparam logic [CW-1:0] K_LAST = CW'(NIB - 1);

  state_e              state_q;
  logic                prio_q;
  logic                id_q;
  logic                carry_q;
  logic [CW-1:0]       k_q;
  logic [NIB-1:0][3:0] a_q;
  logic [NIB-1:0][3:0] b_q;
  logic [NIB-1:0][3:0] sum_q;

  logic                grant;
  logic [3:0]          nib_a;
  logic [3:0]          nib_b;
  logic [3:0]          nib_s;
  logic                nib_c4;

  // Grant the lone valid requester, or the remembered priority when both ask
  always_comb begin
    grant = prio_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  // Readies are gated by rst so nothing is acknowledged in the reset cycle
  assign req0_ready = !rst && (state_q == ST_IDLE) && req0_valid && !grant;
  assign req1_ready = !rst && (state_q == ST_IDLE) && req1_valid &&  grant;

  assign nib_a = a_q[k_q];
  assign nib_b = b_q[k_q];

  ripple_carry_4_bit_adder u_rca (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .c0_i (carry_q),
    .s_o  (nib_s),
    .c4_o (nib_c4)
  );

  // FSM: capture an accepted operation, run NIB adder passes, hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      carry_q <= 1'b0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_ready || req1_ready) begin
            a_q     <= grant ? req1_a : req0_a;
            b_q     <= grant ? req1_b : req0_b;
            carry_q <= grant ? req1_cin : req0_cin;
            id_q    <= grant;
            k_q     <= '0;
            sum_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_q[k_q] <= nib_s;
          carry_q    <= nib_c4;
          if (k_q == K_LAST) begin
            state_q <= ST_DONE;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q <= ST_IDLE;
            prio_q  <= ~id_q;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Response fields come straight from registers, so they stay stable while stalled
  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_share_sched.sv
// tb/tb_adder_share_sched.sv - randomized self-checking bench for adder_share_sched
module tb_adder_share_sched;

  localparam int W    = 16;
  localparam int NIBS = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid, req0_cin, req1_cin, rsp_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  int   total = 0;
  int   bad   = 0;
  logic prio_m;

  always #5 clk = ~clk;

  adder_share_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  // Reference: full-width sum with the carry-out as the extra top bit
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    return r;
  endfunction

  function automatic logic grant_m(input logic v0, input logic v1);
    if (v0 && v1) return prio_m;
    return v1;
  endfunction

  // Present an operation, wait for acceptance, then wait for rsp_valid; reports what was observed
  task automatic issue(input logic v0, input logic v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                       output int gid, output int lat, output logic [W-1:0] s,
                       output logic co, output logic id, output logic busy_ok);
    gid = -1; lat = 0; s = '0; co = 1'b0; id = 1'b0; busy_ok = 1'b1;
    req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_a = a1; req1_b = b1; req1_cin = c1;
    req0_valid = v0; req1_valid = v1;
    #1;
    for (int i = 0; i < 20 && gid < 0; i++) begin
      if (req0_ready && req1_ready) gid = 2;
      else if (req0_ready) gid = 0;
      else if (req1_ready) gid = 1;
      else begin @(posedge clk); #1; end
    end
    if (gid < 0 || gid == 2) return;
    @(posedge clk); #1;
    if (gid == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!busy || req0_ready || req1_ready) busy_ok = 1'b0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (!busy || req0_ready || req1_ready) busy_ok = 1'b0;
    end
    s = rsp_sum; co = rsp_cout; id = rsp_id;
  endtask

  task automatic finish_rsp();
    rsp_ready  = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    total++;
    if ({rsp_valid, busy, rsp_cout, rsp_id, rsp_sum} !== {4'b0000, {W{1'b0}}}) begin
      bad++; $display("FAIL reset_outputs got=%b%b%b%b_%h exp=0000_0000", rsp_valid, busy, rsp_cout, rsp_id, rsp_sum);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    prio_m = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_req0_only();
    int gid, lat; logic [W-1:0] s; logic co, id, bok; logic [W:0] e;
    e = ref_add(16'h1234, 16'h0FCD, 1'b0);
    issue(1'b1, 1'b0, 16'h1234, 16'h0FCD, 1'b0, '0, '0, 1'b0, gid, lat, s, co, id, bok);
    total++;
    if (gid != 0 || id !== 1'b0) begin
      bad++; $display("FAIL req0_grant got gid=%0d id=%0d exp gid=0 id=0", gid, id);
    end
    total++;
    if (s !== e[W-1:0] || co !== e[W]) begin
      bad++; $display("FAIL req0_sum got=%h/%0d exp=%h/%0d", s, co, e[W-1:0], e[W]);
    end
    total++;
    if (lat != NIBS || bok !== 1'b1) begin
      bad++; $display("FAIL req0_latency got lat=%0d busy_ok=%0d exp lat=%0d busy_ok=1", lat, bok, NIBS);
    end
    finish_rsp();
    prio_m = 1'b1;
  endtask

  task automatic test_req1_carry_ripple();
    int gid, lat; logic [W-1:0] s; logic co, id, bok; logic [W:0] e;
    e = ref_add(16'hFFFF, 16'h0000, 1'b1);
    issue(1'b0, 1'b1, '0, '0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, gid, lat, s, co, id, bok);
    total++;
    if (gid != 1 || id !== 1'b1 || lat != NIBS) begin
      bad++; $display("FAIL req1_grant got gid=%0d id=%0d lat=%0d exp gid=1 id=1 lat=%0d", gid, id, lat, NIBS);
    end
    total++;
    if (s !== e[W-1:0] || co !== e[W]) begin
      bad++; $display("FAIL req1_ripple got=%h/%0d exp=%h/%0d", s, co, e[W-1:0], e[W]);
    end
    finish_rsp();
    prio_m = 1'b0;
  endtask

  task automatic test_no_stale_carry();
    int gid, lat; logic [W-1:0] s; logic co, id, bok; logic [W:0] e;
    e = ref_add(16'hFFFF, 16'hFFFF, 1'b1);
    issue(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, '0, '0, 1'b0, gid, lat, s, co, id, bok);
    total++;
    if (gid != 0 || s !== e[W-1:0] || co !== e[W]) begin
      bad++; $display("FAIL max_add got gid=%0d %h/%0d exp gid=0 %h/%0d", gid, s, co, e[W-1:0], e[W]);
    end
    finish_rsp();
    prio_m = 1'b1;
    e = ref_add(16'h000F, 16'h0001, 1'b0);
    issue(1'b1, 1'b0, 16'h000F, 16'h0001, 1'b0, '0, '0, 1'b0, gid, lat, s, co, id, bok);
    total++;
    if (gid != 0 || s !== e[W-1:0] || co !== e[W]) begin
      bad++; $display("FAIL stale_carry got gid=%0d %h/%0d exp gid=0 %h/%0d", gid, s, co, e[W-1:0], e[W]);
    end
    finish_rsp();
    prio_m = 1'b1;
  endtask

  task automatic test_stall();
    int gid, lat; logic [W-1:0] s, a0, b0, a1, b1; logic co, id, bok, c0, c1, stable_ok;
    logic [W:0] e;
    a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
    a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
    e = ref_add(a0, b0, c0);
    issue(1'b1, 1'b0, a0, b0, c0, a1, b1, c1, gid, lat, s, co, id, bok);
    total++;
    if (gid != 0 || s !== e[W-1:0] || co !== e[W]) begin
      bad++; $display("FAIL stall_first got gid=%0d %h/%0d exp gid=0 %h/%0d", gid, s, co, e[W-1:0], e[W]);
    end
    req1_valid = 1'b1;
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_sum !== s || rsp_cout !== co || req0_ready || req1_ready) stable_ok = 1'b0;
    end
    total++;
    if (stable_ok !== 1'b1) begin
      bad++; $display("FAIL stall_hold got stable=%0d exp stable=1", stable_ok);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    prio_m = 1'b1;
    total++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      bad++; $display("FAIL stall_next_accept got r0=%0d r1=%0d exp r0=0 r1=1", req0_ready, req1_ready);
    end
    e = ref_add(a1, b1, c1);
    issue(1'b0, 1'b1, a0, b0, c0, a1, b1, c1, gid, lat, s, co, id, bok);
    total++;
    if (gid != 1 || id !== 1'b1 || s !== e[W-1:0] || co !== e[W]) begin
      bad++; $display("FAIL stall_second got gid=%0d %h/%0d exp gid=1 %h/%0d", gid, s, co, e[W-1:0], e[W]);
    end
    finish_rsp();
    prio_m = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int gid, lat, waited; logic [W-1:0] s; logic co, id, bok, seen;
    issue(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0, '0, '0, 1'b0, gid, lat, s, co, id, bok);
    finish_rsp();
    prio_m = 1'b1;
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'b1;
    req1_valid = 1'b1;
    #1;
    waited = 0;
    while (!req1_ready && waited < 20) begin @(posedge clk); #1; waited++; end
    total++;
    if (waited >= 20) begin
      bad++; $display("FAIL midrst_accept got=timeout exp=req1_ready");
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prio_m = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid || busy) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL midrst_no_rsp got activity=%0d exp=0", seen);
    end
    issue(1'b1, 1'b1, 16'h8000, 16'h8000, 1'b0, W'($urandom), W'($urandom), 1'b1, gid, lat, s, co, id, bok);
    total++;
    if (gid != 0 || id !== 1'b0 || s !== 16'h0000 || co !== 1'b1) begin
      bad++; $display("FAIL midrst_after got gid=%0d %h/%0d exp gid=0 0000/1", gid, s, co);
    end
    finish_rsp();
    prio_m = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [W:0] q_res[$];
    logic       q_id[$];
    logic [W:0] e;
    logic       eid;
    int         rsps, last_acc, cyc, acc;
    rsps = 0; last_acc = -1; cyc = 0;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    prio_m = 1'b0;
    req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    while (rsps < 4 && cyc < 80) begin
      if (rsp_valid) begin
        total++;
        if (q_id.size() == 0) begin
          bad++; $display("FAIL b2b_rsp got=unexpected_response exp=none");
        end else begin
          e = q_res.pop_front();
          eid = q_id.pop_front();
          if (rsp_id !== eid || rsp_sum !== e[W-1:0] || rsp_cout !== e[W]) begin
            bad++; $display("FAIL b2b_rsp got id=%0d %h/%0d exp id=%0d %h/%0d", rsp_id, rsp_sum, rsp_cout, eid, e[W-1:0], e[W]);
          end
          prio_m = ~eid;
        end
        rsps++;
      end
      acc = -1;
      if (req0_ready || req1_ready) begin
        total++;
        if ((req0_ready && req1_ready) || req1_ready !== prio_m ||
            (last_acc >= 0 && cyc - last_acc != NIBS + 2)) begin
          bad++; $display("FAIL b2b_grant got r0=%0d r1=%0d gap=%0d exp r1=%0d gap=%0d", req0_ready, req1_ready, cyc - last_acc, prio_m, NIBS + 2);
        end
        acc = req1_ready ? 1 : 0;
        q_id.push_back(req1_ready);
        q_res.push_back(req1_ready ? ref_add(req1_a, req1_b, req1_cin) : ref_add(req0_a, req0_b, req0_cin));
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc == 0) begin
        req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom);
      end else if (acc == 1) begin
        req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom);
      end
    end
    total++;
    if (rsps != 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", rsps);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    prio_m = 1'b0;
  endtask

  task automatic test_random();
    int gid, lat; logic [W-1:0] s, a0, b0, a1, b1; logic co, id, bok, c0, c1, v0, v1, eg;
    logic [W:0] e;
    for (int n = 0; n < 16; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
      eg = grant_m(v0, v1);
      e = eg ? ref_add(a1, b1, c1) : ref_add(a0, b0, c0);
      issue(v0, v1, a0, b0, c0, a1, b1, c1, gid, lat, s, co, id, bok);
      total++;
      if (gid != (eg ? 1 : 0) || id !== eg || lat != NIBS || bok !== 1'b1 ||
          s !== e[W-1:0] || co !== e[W]) begin
        bad++; $display("FAIL rand_op%0d got gid=%0d id=%0d lat=%0d %h/%0d exp gid=%0d lat=%0d %h/%0d", n, gid, id, lat, s, co, eg, NIBS, e[W-1:0], e[W]);
      end
      finish_rsp();
      prio_m = ~eg;
    end
  endtask

  initial begin
    test_reset();
    test_req0_only();
    test_req1_carry_ripple();
    test_no_stale_carry();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
